// File: rtl/ttt_turn_controller.sv
// Turn sequencer for a two-player tic-tac-toe game: arbitrates X/O move requests,
// owns the board registers and resolves win/draw one cycle after each accepted move.
module ttt_turn_controller #(
  parameter logic FIRST_PLAYER   = 1'b0,
  parameter int   TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       x_valid,
  input  logic [3:0] x_cell,
  input  logic       o_valid,
  input  logic [3:0] o_cell,
  output logic       x_ack,
  output logic       x_nack,
  output logic       o_ack,
  output logic       o_nack,
  output logic       turn,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [8:0] win_line,
  output logic       timeout
);

  typedef enum logic [1:0] {
    TURN  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  // Lines in priority order: rows, columns, diagonal 0-4-8, diagonal 2-4-6.
  localparam logic [8:0] LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  function automatic logic [8:0] cell_bit(input logic [3:0] c);
    logic [8:0] m;
    m = '0;
    if (c <= 4'd8) m = 9'b1 << c;
    return m;
  endfunction

  function automatic logic [8:0] first_win(input logic [8:0] b);
    logic [8:0] hit;
    hit = '0;
    for (int i = 0; i < 8; i++) begin
      if ((hit == 9'd0) && ((b & LINES[i]) == LINES[i])) hit = LINES[i];
    end
    return hit;
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;

  logic       cur_valid;
  logic [3:0] cur_cell;
  logic [8:0] cur_mask;
  logic       legal;
  logic [8:0] mover_board;
  logic [8:0] win_mask;
  logic       board_full;

  always_comb begin
    cur_valid   = turn ? o_valid : x_valid;
    cur_cell    = turn ? o_cell  : x_cell;
    cur_mask    = cell_bit(cur_cell);
    legal       = (cur_cell <= 4'd8) && (((board_x | board_o) & cur_mask) == 9'd0);
    mover_board = turn ? board_o : board_x;
    win_mask    = first_win(mover_board);
    board_full  = ((board_x | board_o) == 9'h1FF);
  end

  always_ff @(posedge clk) begin
    x_ack   <= 1'b0;
    x_nack  <= 1'b0;
    o_ack   <= 1'b0;
    o_nack  <= 1'b0;
    timeout <= 1'b0;
    if (rst || new_game) begin
      state     <= TURN;
      turn      <= FIRST_PLAYER;
      board_x   <= '0;
      board_o   <= '0;
      game_over <= 1'b0;
      winner    <= 2'b00;
      win_line  <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        TURN: begin
          // The player not on turn is always refused.
          if (x_valid && turn)  x_nack <= 1'b1;
          if (o_valid && !turn) o_nack <= 1'b1;
          if (cur_valid && legal) begin
            if (turn) begin
              board_o <= board_o | cur_mask;
              o_ack   <= 1'b1;
            end else begin
              board_x <= board_x | cur_mask;
              x_ack   <= 1'b1;
            end
            cnt   <= '0;
            state <= CHECK;
          end else begin
            if (cur_valid) begin
              if (turn) o_nack <= 1'b1;
              else      x_nack <= 1'b1;
            end
            if (TIMEOUT_CYCLES > 0) begin
              if (cnt == CNT_LAST) begin
                timeout <= 1'b1;
                turn    <= ~turn;
                cnt     <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        CHECK: begin
          x_nack <= x_valid;
          o_nack <= o_valid;
          if (win_mask != 9'd0) begin
            winner    <= turn ? 2'b10 : 2'b01;
            win_line  <= win_mask;
            game_over <= 1'b1;
            state     <= DONE;
          end else if (board_full) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
            state     <= DONE;
          end else begin
            turn  <= ~turn;
            state <= TURN;
          end
        end
        DONE: begin
          x_nack <= x_valid;
          o_nack <= o_valid;
          cnt    <= '0;
        end
        default: state <= TURN;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: directed game scenarios with literal expectations plus
// randomized play compared each cycle against a cell-array model of the game rules.
module tb_ttt_turn_controller;

  localparam int TO = 8;

  logic       clk;
  logic       rst;
  logic       new_game;
  logic       x_valid;
  logic [3:0] x_cell;
  logic       o_valid;
  logic [3:0] o_cell;
  logic       x_ack, x_nack, o_ack, o_nack;
  logic       turn;
  logic [8:0] board_x, board_o;
  logic       game_over;
  logic [1:0] winner;
  logic [8:0] win_line;
  logic       timeout;

  ttt_turn_controller #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .x_valid(x_valid), .x_cell(x_cell), .o_valid(o_valid), .o_cell(o_cell),
    .x_ack(x_ack), .x_nack(x_nack), .o_ack(o_ack), .o_nack(o_nack),
    .turn(turn), .board_x(board_x), .board_o(board_o), .game_over(game_over),
    .winner(winner), .win_line(win_line), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game-rule model: each cell holds 0 (empty), 1 (X) or 2 (O).
  int   cells [9];
  bit   m_turn;
  int   m_phase;      // 0 playing, 1 result pending, 2 finished
  int   m_idle;
  bit   m_over;
  int   m_winner;
  logic [8:0] m_line;
  bit   m_xack, m_xnack, m_oack, m_onack, m_to;
  bit   started;

  function automatic logic [8:0] held_by(input int who);
    logic [8:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) if (cells[i] == who) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [8:0] find_win(input int who);
    logic [8:0] res;
    res = '0;
    for (int l = 0; l < 8; l++) begin
      bit all;
      logic [8:0] m;
      all = 1'b1;
      m = '0;
      for (int k = 0; k < 3; k++) begin
        int c;
        if (l < 3)       c = l * 3 + k;
        else if (l < 6)  c = k * 3 + (l - 3);
        else if (l == 6) c = 4 * k;
        else             c = 2 + 2 * k;
        if (cells[c] != who) all = 1'b0;
        m[c] = 1'b1;
      end
      if (all && res == 9'd0) res = m;
    end
    return res;
  endfunction

  function automatic bit board_full();
    for (int i = 0; i < 9; i++) if (cells[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit placed;
    bit cv;
    int cc;
    logic [8:0] w;
    m_xack = 0; m_xnack = 0; m_oack = 0; m_onack = 0; m_to = 0;
    if (rst || new_game) begin
      for (int i = 0; i < 9; i++) cells[i] = 0;
      m_turn = 1'b0; m_phase = 0; m_idle = 0;
      m_over = 1'b0; m_winner = 0; m_line = '0;
      started = 1'b1;
    end else if (m_phase == 0) begin
      placed = 1'b0;
      cv = m_turn ? o_valid : x_valid;
      cc = m_turn ? int'(o_cell) : int'(x_cell);
      if (m_turn ? x_valid : o_valid) begin
        if (m_turn) m_xnack = 1; else m_onack = 1;
      end
      if (cv) begin
        if (cc <= 8 && cells[cc] == 0) begin
          cells[cc] = m_turn ? 2 : 1;
          placed = 1'b1;
          if (m_turn) m_oack = 1; else m_xack = 1;
        end else begin
          if (m_turn) m_onack = 1; else m_xnack = 1;
        end
      end
      if (placed) begin
        m_idle = 0;
        m_phase = 1;
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_to = 1; m_turn = ~m_turn; m_idle = 0;
        end
      end
    end else begin
      m_xnack = x_valid;
      m_onack = o_valid;
      if (m_phase == 1) begin
        w = find_win(m_turn ? 2 : 1);
        if (w != 9'd0) begin
          m_winner = m_turn ? 2 : 1; m_line = w; m_over = 1'b1; m_phase = 2;
        end else if (board_full()) begin
          m_winner = 3; m_over = 1'b1; m_phase = 2;
        end else begin
          m_turn = ~m_turn; m_phase = 0;
        end
      end
    end
  endtask

  initial begin
    started = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("x_ack", 32'(x_ack), 32'(m_xack));
        chk("x_nack", 32'(x_nack), 32'(m_xnack));
        chk("o_ack", 32'(o_ack), 32'(m_oack));
        chk("o_nack", 32'(o_nack), 32'(m_onack));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("turn", 32'(turn), 32'(m_turn));
        chk("board_x", 32'(board_x), 32'(held_by(1)));
        chk("board_o", 32'(board_o), 32'(held_by(2)));
        chk("game_over", 32'(game_over), 32'(m_over));
        chk("winner", 32'(winner), 32'(m_winner));
        chk("win_line", 32'(win_line), 32'(m_line));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input bit p, input int c);
    if (!p) begin x_valid = 1'b1; x_cell = 4'(c); end
    else    begin o_valid = 1'b1; o_cell = 4'(c); end
    step();
    x_valid = 1'b0;
    o_valid = 1'b0;
  endtask

  task automatic restart();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  int seq3 [5] = '{0, 3, 1, 4, 2};
  int seq4 [9] = '{0, 4, 1, 2, 6, 3, 5, 7, 8};

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; new_game = 1'b0;
    x_valid = 1'b0; x_cell = '0; o_valid = 1'b0; o_cell = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_board_x", 32'(board_x), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);

    // First move and turn-change latency
    move(1'b0, 4);
    chk("t1_x_ack", 32'(x_ack), 32'd1);
    chk("t1_board_x", 32'(board_x), 32'h010);
    chk("t1_turn_early", 32'(turn), 32'd0);
    step();
    chk("t1_x_ack_drop", 32'(x_ack), 32'd0);
    chk("t1_turn", 32'(turn), 32'd1);

    // Occupied cell and out-of-range cell
    move(1'b1, 4);
    chk("t2_o_nack_occ", 32'(o_nack), 32'd1);
    chk("t2_board_o", 32'(board_o), 32'd0);
    chk("t2_board_x", 32'(board_x), 32'h010);
    chk("t2_turn", 32'(turn), 32'd1);
    move(1'b1, 9);
    chk("t2_o_nack_range", 32'(o_nack), 32'd1);

    // X wins along the top row
    restart();
    for (int i = 0; i < 5; i++) begin
      move(i[0], seq3[i]);
      step();
    end
    chk("t3_winner", 32'(winner), 32'd1);
    chk("t3_win_line", 32'(win_line), 32'h007);
    chk("t3_game_over", 32'(game_over), 32'd1);
    move(1'b0, 5);
    chk("t3_x_nack_done", 32'(x_nack), 32'd1);
    chk("t3_board_frozen", 32'(board_x), 32'h007);

    // Draw
    restart();
    for (int i = 0; i < 9; i++) begin
      move(i[0], seq4[i]);
      step();
    end
    chk("t4_winner", 32'(winner), 32'd3);
    chk("t4_full", 32'(board_x | board_o), 32'h1FF);
    chk("t4_win_line", 32'(win_line), 32'd0);

    // Idle X forfeits on the 8th turn cycle
    restart();
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i == TO - 1) chk("t5_no_timeout_yet", 32'(timeout), 32'd0);
    end
    chk("t5_timeout", 32'(timeout), 32'd1);
    chk("t5_turn", 32'(turn), 32'd1);
    chk("t5_board_x", 32'(board_x), 32'd0);

    // new_game mid-game, rst with new_game, simultaneous requests
    restart();
    move(1'b0, 0); step();
    move(1'b1, 4); step();
    x_valid = 1'b1; x_cell = 4'd1; new_game = 1'b1;
    step();
    x_valid = 1'b0; new_game = 1'b0;
    chk("t6_ng_x_ack", 32'(x_ack), 32'd0);
    chk("t6_ng_x_nack", 32'(x_nack), 32'd0);
    chk("t6_ng_boards", 32'({board_x, board_o}), 32'd0);
    chk("t6_ng_turn", 32'(turn), 32'd0);
    move(1'b0, 2); step();
    rst = 1'b1; new_game = 1'b1;
    step();
    rst = 1'b0; new_game = 1'b0;
    chk("t6_rst_board_x", 32'(board_x), 32'd0);
    chk("t6_rst_turn", 32'(turn), 32'd0);
    x_valid = 1'b1; x_cell = 4'd4; o_valid = 1'b1; o_cell = 4'd5;
    step();
    x_valid = 1'b0; o_valid = 1'b0;
    chk("t6_both_x_ack", 32'(x_ack), 32'd1);
    chk("t6_both_o_nack", 32'(o_nack), 32'd1);
    chk("t6_both_o_ack", 32'(o_ack), 32'd0);
    chk("t6_both_board_o", 32'(board_o), 32'd0);

    // Randomized play against the model
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      new_game = ($urandom_range(0, 79) == 0);
      x_valid  = ($urandom_range(0, 9) < 3);
      o_valid  = ($urandom_range(0, 9) < 3);
      x_cell   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      o_cell   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      step();
    end
    rst = 1'b0; new_game = 1'b0; x_valid = 1'b0; o_valid = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
